// File: rtl/bitblade_pkg.sv
// Shared types and helpers for the BitBlade slice-pair accumulator: precision codes,
// FSM states and the slice-count lookup used to sequence slice pairs.
package bitblade_pkg;

   typedef enum logic [1:0] {
      PREC_2B = 2'd0,
      PREC_4B = 2'd1,
      PREC_8B = 2'd2
   } prec_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Code 3 is not a legal precision; it is folded onto 8b.
   function automatic prec_e decode_prec(input logic [1:0] code);
      case (code)
         2'd0:    return PREC_2B;
         2'd1:    return PREC_4B;
         default: return PREC_8B;
      endcase
   endfunction

   function automatic logic [2:0] slices(input prec_e p);
      case (p)
         PREC_2B: return 3'd1;
         PREC_4B: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [1:0] last_slice(input prec_e p);
      return 2'(slices(p) - 3'd1);
   endfunction

endpackage

// File: rtl/bitblade_pp_align.sv
// Sign-extends one 6-bit partial product to accumulator width and weights it by
// 2^(2*(i_idx+w_idx)) so it can be added straight into the running sum.
module bitblade_pp_align #(
   parameter int ACC_W = 32
) (
   input  logic [5:0]       pp,
   input  logic [1:0]       i_idx,
   input  logic [1:0]       w_idx,
   output logic [ACC_W-1:0] term
);

   logic [3:0]       shamt;
   logic [ACC_W-1:0] ext;

   assign shamt = ({2'b00, i_idx} + {2'b00, w_idx}) << 1;
   assign ext   = {{(ACC_W-6){pp[5]}}, pp};
   assign term  = ext << shamt;

endmodule

// File: rtl/bitblade_pp_accumulator.sv
// Consumer end of the 2b x 2b multiplier array: walks slice pairs (i inner, w outer) per
// element, accumulates aligned partial products and returns one result per job.
module bitblade_pp_accumulator
   import bitblade_pkg::*;
#(
   parameter int ACC_W = 32,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       cfg_prec_i,
   input  logic [1:0]       cfg_prec_w,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             pp_valid,
   output logic             pp_ready,
   input  logic [5:0]       pp,
   output logic [1:0]       i_idx,
   output logic [1:0]       w_idx,
   output logic             sign_i,
   output logic             sign_w,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res,
   output logic             busy,
   output logic [1:0]       state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // a valid source holds its payload stable until that edge, ready may change freely.

   state_e           state_q, state_d;
   prec_e            prec_i_q, prec_w_q;
   logic [LEN_W-1:0] len_q, elem_q;
   logic [1:0]       i_idx_q, w_idx_q;
   logic             first_q;
   logic [ACC_W-1:0] acc_q, acc_d, term;
   logic             beat, last_i, last_w, last_elem, last_beat;

   assign beat      = (state_q == ACC) && pp_valid;
   assign last_i    = (i_idx_q == last_slice(prec_i_q));
   assign last_w    = (w_idx_q == last_slice(prec_w_q));
   assign last_elem = (elem_q == len_q);
   assign last_beat = beat && last_i && last_w && last_elem;

   bitblade_pp_align #(.ACC_W(ACC_W)) u_align (
      .pp    (pp),
      .i_idx (i_idx_q),
      .w_idx (w_idx_q),
      .term  (term)
   );

   // The previous result stays visible until the first beat of the next job replaces it.
   assign acc_d = first_q ? term : (acc_q + term);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = ACC;
         ACC:     if (last_beat) state_d = DONE;
         DONE:    if (res_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      pp_ready  = (state_q == ACC);
      res_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      sign_i    = pp_ready && last_i;
      sign_w    = pp_ready && last_w;
      i_idx     = i_idx_q;
      w_idx     = w_idx_q;
      res       = acc_q;
      state_o   = state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prec_i_q <= PREC_2B;
         prec_w_q <= PREC_2B;
         len_q    <= '0;
         elem_q   <= '0;
         i_idx_q  <= '0;
         w_idx_q  <= '0;
         first_q  <= 1'b0;
         acc_q    <= '0;
      end else if (state_q == IDLE && start) begin
         prec_i_q <= decode_prec(cfg_prec_i);
         prec_w_q <= decode_prec(cfg_prec_w);
         len_q    <= cfg_len;
         elem_q   <= '0;
         i_idx_q  <= '0;
         w_idx_q  <= '0;
         first_q  <= 1'b1;
      end else if (beat) begin
         acc_q   <= acc_d;
         first_q <= 1'b0;
         if (last_i) begin
            i_idx_q <= '0;
            if (last_w) begin
               w_idx_q <= '0;
               elem_q  <= elem_q + LEN_W'(1);
            end else begin
               w_idx_q <= w_idx_q + 2'd1;
            end
         end else begin
            i_idx_q <= i_idx_q + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_bitblade_pp_accumulator.sv
// Bench for bitblade_pp_accumulator: drives slice-pair partial products derived from
// operand values and compares each result with the plain integer dot product.
module tb_bitblade_pp_accumulator;

   localparam int ACC_W = 32;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       cfg_prec_i = '0;
   logic [1:0]       cfg_prec_w = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             pp_valid = 1'b0;
   logic [5:0]       pp = '0;
   logic             res_ready = 1'b0;
   logic             pp_ready, sign_i, sign_w, res_valid, busy;
   logic [1:0]       i_idx, w_idx, state_o;
   logic [ACC_W-1:0] res;

   bitblade_pp_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_prec_i (cfg_prec_i),
      .cfg_prec_w (cfg_prec_w),
      .cfg_len    (cfg_len),
      .pp_valid   (pp_valid),
      .pp_ready   (pp_ready),
      .pp         (pp),
      .i_idx      (i_idx),
      .w_idx      (w_idx),
      .sign_i     (sign_i),
      .sign_w     (sign_w),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res        (res),
      .busy       (busy),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   int               n_total = 0;
   int               n_bad = 0;
   logic [ACC_W-1:0] exp_q[$];
   int               op_a[256];
   int               op_w[256];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int n_slices(input int p);
      return (p == 0) ? 1 : ((p == 1) ? 2 : 4);
   endfunction

   // Slice k of an n-slice operand: top slice is signed, lower slices unsigned.
   function automatic int slice_val(input int v, input int k, input int n);
      int b;
      b = (v >>> (2 * k)) & 3;
      if (k == n - 1 && b >= 2) b -= 4;
      return b;
   endfunction

   function automatic int rand_op(input int n);
      int half;
      half = 1 << (2 * n - 1);
      return int'($urandom_range(0, 2 * half - 1)) - half;
   endfunction

   task automatic check_all_zero(input string tag);
      check_val({tag, "_pp_ready"},  pp_ready,  0);
      check_val({tag, "_res_valid"}, res_valid, 0);
      check_val({tag, "_busy"},      busy,      0);
      check_val({tag, "_i_idx"},     i_idx,     0);
      check_val({tag, "_w_idx"},     w_idx,     0);
      check_val({tag, "_sign_i"},    sign_i,    0);
      check_val({tag, "_sign_w"},    sign_w,    0);
      check_val({tag, "_res"},       res,       0);
      check_val({tag, "_state"},     state_o,   0);
   endtask

   // One job over op_a/op_w[0..len]. abort_at>0 pulls reset after that many beats.
   task automatic run_job(input int pi, input int pw, input int len, input bit gaps,
                          input int hold, input int abort_at);
      int               ni, nw, beats;
      logic [ACC_W-1:0] expv, got_exp;
      ni    = n_slices(pi);
      nw    = n_slices(pw);
      beats = 0;
      expv  = '0;
      for (int e = 0; e <= len; e++) expv += ACC_W'(op_a[e] * op_w[e]);
      if (abort_at <= 0) exp_q.push_back(expv);

      @(negedge clk);
      check_val("idle_busy", busy, 0);
      cfg_prec_i = 2'(pi);
      cfg_prec_w = 2'(pw);
      cfg_len    = LEN_W'(len);
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      cfg_prec_i = 2'($urandom);
      cfg_prec_w = 2'($urandom);
      cfg_len    = LEN_W'($urandom);

      for (int e = 0; e <= len; e++) begin
         for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < ni; i++) begin
               if (gaps) begin
                  while ($urandom_range(0, 2) == 0) begin
                     pp_valid = 1'b0;
                     pp       = 6'($urandom);
                     start    = 1'($urandom);
                     check_val("gap_busy", busy, 1);
                     @(negedge clk);
                     start = 1'b0;
                  end
               end
               pp_valid = 1'b1;
               pp       = 6'(slice_val(op_a[e], i, ni) * slice_val(op_w[e], w, nw));
               check_val("pp_ready", pp_ready, 1);
               check_val("i_idx", i_idx, i);
               check_val("w_idx", w_idx, w);
               check_val("sign_i", sign_i, (i == ni - 1));
               check_val("sign_w", sign_w, (w == nw - 1));
               @(negedge clk);
               beats++;
               if (beats == abort_at) begin
                  pp_valid = 1'b0;
                  rst_n    = 1'b0;
                  #1;
                  check_all_zero("abort");
                  @(negedge clk);
                  rst_n = 1'b1;
                  return;
               end
            end
         end
      end
      pp_valid = 1'b0;

      got_exp = exp_q.pop_front();
      check_val("res_valid", res_valid, 1);
      check_val("done_busy", busy, 1);
      check_val("done_pp_ready", pp_ready, 0);
      check_val("res", res, got_exp);

      for (int h = 0; h < hold; h++) begin
         res_ready = 1'b0;
         start     = 1'b1;
         @(negedge clk);
         check_val("hold_res_valid", res_valid, 1);
         check_val("hold_res", res, got_exp);
         check_val("hold_pp_ready", pp_ready, 0);
      end
      start     = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check_val("accept_res_valid", res_valid, 0);
      check_val("accept_busy", busy, 0);
      check_val("accept_res_hold", res, got_exp);
   endtask

   initial begin
      int pi, pw, len;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      op_a[0] = -2; op_w[0] = 1;
      run_job(0, 0, 0, 1'b0, 0, 0);

      op_a[0] = -7; op_w[0] = 3;
      run_job(1, 1, 0, 1'b0, 0, 0);

      for (int e = 0; e < 4; e++) begin op_a[e] = rand_op(4); op_w[e] = rand_op(4); end
      run_job(2, 2, 3, 1'b0, 0, 0);

      for (int e = 0; e < 2; e++) begin op_a[e] = rand_op(2); op_w[e] = rand_op(4); end
      run_job(1, 2, 1, 1'b0, 5, 0);

      for (int e = 0; e < 3; e++) begin op_a[e] = rand_op(4); op_w[e] = rand_op(2); end
      run_job(2, 1, 2, 1'b0, 0, 0);
      run_job(2, 1, 2, 1'b1, 0, 0);

      op_a[0] = -7; op_w[0] = 3;
      run_job(1, 1, 0, 1'b0, 0, 2);
      run_job(1, 1, 0, 1'b0, 0, 0);

      for (int j = 0; j < 8; j++) begin
         pi  = int'($urandom_range(0, 3));
         pw  = int'($urandom_range(0, 3));
         len = int'($urandom_range(0, 4));
         for (int e = 0; e <= len; e++) begin
            op_a[e] = rand_op(n_slices(pi));
            op_w[e] = rand_op(n_slices(pw));
         end
         run_job(pi, pw, len, 1'($urandom), int'($urandom_range(0, 2)), 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
